pfb_chsel_ctrl: RTL and testbench

- Frame-sequencing controller on the PFB output stream (firs → pfb_switch → ssrfft → pimod output, 2*L lanes of 16-bit I/Q per beat, tlast on the last beat of each N-channel frame).
- Tracks frame alignment and detects tlast sync loss.
- Latches channel-select and QOUT configuration only on frame boundaries, so the datapath never sees a mid-frame change.
- Extracts the one selected channel as a single-lane stream for downstream per-channel processing.

---
 rtl/pfb_chsel_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pfb_chsel_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pfb_chsel_ctrl.sv
// Frame-sequencing controller for the PFB output stream: tracks tlast alignment,
// latches channel/QOUT config on frame boundaries and extracts one channel.
module pfb_chsel_ctrl #(
  parameter int N = 64,
  parameter int L = 4
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  input  logic [2*L*32-1:0]        s_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic [31:0]              m_axis_tdata,
  output logic [$clog2(N)-1:0]     m_axis_tuser,
  input  logic [31:0]              CH_REG,
  input  logic [31:0]              QOUT_REG,
  input  logic                     ERR_CLR,
  output logic [31:0]              qout_o,
  output logic                     sync_err,
  output logic [31:0]              frame_cnt
);

  localparam int LANES = 2 * L;
  localparam int DW    = LANES * 32;
  localparam int LW    = $clog2(LANES);
  localparam int CHW   = $clog2(N);
  localparam int NB    = N / LANES;
  localparam int CW    = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

  typedef enum logic [0:0] {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t          state_r, state_nxt;
  logic [CW-1:0]   cnt_r, cnt_nxt;
  logic [CHW-1:0]  ch_act_r, ch_act_nxt;
  logic [31:0]     qout_r, qout_nxt;
  logic            sync_err_r, sync_err_nxt;
  logic [31:0]     frame_cnt_r, frame_cnt_nxt;
  logic            m_valid_r, m_valid_nxt;
  logic [31:0]     m_data_r, m_data_nxt;
  logic [CHW-1:0]  m_user_r, m_user_nxt;

  logic [CW-1:0]   sel_beat_s;
  logic [LW-1:0]   sel_lane_s;
  logic [31:0]     lane_data_s;
  logic            err_set_s;
  logic            unused_ch_s;

  // Mux-free lane select: OR of masked lanes, only the matching lane survives.
  function automatic logic [31:0] lane_pick(input logic [DW-1:0] d, input logic [LW-1:0] idx);
    logic [31:0] r;
    r = 32'd0;
    for (int k = 0; k < LANES; k++) begin
      r = r | ({32{idx == LW'(k)}} & d[k*32 +: 32]);
    end
    return r;
  endfunction

  assign unused_ch_s = ^CH_REG[31:CHW];
  assign sel_beat_s  = CW'(ch_act_r >> LW);
  assign sel_lane_s  = ch_act_r[LW-1:0];
  assign lane_data_s = lane_pick(s_axis_tdata, sel_lane_s);

  // Next-state, counters, config capture and extraction.
  always_comb begin
    state_nxt     = state_r;
    cnt_nxt       = cnt_r;
    ch_act_nxt    = ch_act_r;
    qout_nxt      = qout_r;
    frame_cnt_nxt = frame_cnt_r;
    m_valid_nxt   = 1'b0;
    m_data_nxt    = m_data_r;
    m_user_nxt    = m_user_r;
    err_set_s     = 1'b0;

    case (state_r)
      SYNC_WAIT: begin
        cnt_nxt    = {CW{1'b0}};
        ch_act_nxt = CH_REG[CHW-1:0];
        qout_nxt   = QOUT_REG;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_nxt = RUN;
        end else begin
          state_nxt = SYNC_WAIT;
        end
      end
      RUN: begin
        if (s_axis_tvalid) begin
          // Extraction sees the pre-boundary ch_act; a missing-tlast beat yields nothing.
          if ((cnt_r == sel_beat_s) && !(!s_axis_tlast && (cnt_r == LAST_BEAT))) begin
            m_valid_nxt = 1'b1;
            m_data_nxt  = lane_data_s;
            m_user_nxt  = ch_act_r;
          end else begin
            m_valid_nxt = 1'b0;
          end

          if (s_axis_tlast) begin
            cnt_nxt    = {CW{1'b0}};
            ch_act_nxt = CH_REG[CHW-1:0];
            qout_nxt   = QOUT_REG;
            if (cnt_r == LAST_BEAT) begin
              frame_cnt_nxt = frame_cnt_r + 32'd1;
            end else begin
              err_set_s = 1'b1;
            end
          end else if (cnt_r == LAST_BEAT) begin
            err_set_s = 1'b1;
            cnt_nxt   = {CW{1'b0}};
            state_nxt = SYNC_WAIT;
          end else begin
            cnt_nxt = cnt_r + CW'(1);
          end
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = SYNC_WAIT;
        cnt_nxt   = {CW{1'b0}};
      end
    endcase

    if (err_set_s) begin
      sync_err_nxt = 1'b1;
    end else if (ERR_CLR) begin
      sync_err_nxt = 1'b0;
    end else begin
      sync_err_nxt = sync_err_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r     <= SYNC_WAIT;
      cnt_r       <= {CW{1'b0}};
      ch_act_r    <= {CHW{1'b0}};
      qout_r      <= 32'd0;
      sync_err_r  <= 1'b0;
      frame_cnt_r <= 32'd0;
      m_valid_r   <= 1'b0;
      m_data_r    <= 32'd0;
      m_user_r    <= {CHW{1'b0}};
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      ch_act_r    <= ch_act_nxt;
      qout_r      <= qout_nxt;
      sync_err_r  <= sync_err_nxt;
      frame_cnt_r <= frame_cnt_nxt;
      m_valid_r   <= m_valid_nxt;
      m_data_r    <= m_data_nxt;
      m_user_r    <= m_user_nxt;
    end
  end

  assign m_axis_tvalid = m_valid_r;
  assign m_axis_tdata  = m_data_r;
  assign m_axis_tuser  = m_user_r;
  assign qout_o        = qout_r;
  assign sync_err      = sync_err_r;
  assign frame_cnt     = frame_cnt_r;

endmodule

// File: tb/tb_pfb_chsel_ctrl.sv
// Bench for pfb_chsel_ctrl: directed vector table, then random traffic vs a frame-level model.
module tb_pfb_chsel_ctrl;
  localparam int N = 64;
  localparam int L = 4;
  localparam int LANES = 2 * L;
  localparam int NB = N / LANES;
  localparam int DW = LANES * 32;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic          areset;
  logic          s_axis_tvalid, s_axis_tlast;
  logic [DW-1:0] s_axis_tdata;
  logic          m_axis_tvalid;
  logic [31:0]   m_axis_tdata;
  logic [5:0]    m_axis_tuser;
  logic [31:0]   CH_REG, QOUT_REG;
  logic          ERR_CLR;
  logic [31:0]   qout_o;
  logic          sync_err;
  logic [31:0]   frame_cnt;

  pfb_chsel_ctrl #(.N(N), .L(L)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .CH_REG(CH_REG), .QOUT_REG(QOUT_REG), .ERR_CLR(ERR_CLR),
    .qout_o(qout_o), .sync_err(sync_err), .frame_cnt(frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit rst, v, l, clr;
    int beat, ch, q;
    bit ev;
    int eb, el, eu;
    bit eerr;
    int efc, eq;
  } vec_t;
  vec_t tbl[$];

  // frame-level reference state
  bit          m_sync;
  int          m_pos, m_ch;
  logic [31:0] m_q, m_fc;
  bit          m_err;
  bit          e_v;
  logic [31:0] e_d;
  int          e_u;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] tag_data(input int b);
    logic [DW-1:0] d;
    for (int k = 0; k < LANES; k++) d[k*32 +: 32] = {16'(b), 16'(k)};
    return d;
  endfunction

  task automatic add(input bit rst, v, l, clr, input int beat, ch, q,
                     input bit ev, input int eb, el, eu, input bit eerr, input int efc, eq);
    vec_t r;
    r.rst = rst; r.v = v; r.l = l; r.clr = clr; r.beat = beat; r.ch = ch; r.q = q;
    r.ev = ev; r.eb = eb; r.el = el; r.eu = eu; r.eerr = eerr; r.efc = efc; r.eq = eq;
    tbl.push_back(r);
  endtask

  task automatic model_step(input bit rst, v, l, clr, input logic [DW-1:0] d,
                            input logic [31:0] ch, q);
    bit set;
    set = 1'b0;
    e_v = 1'b0;
    if (rst) begin
      m_sync = 0; m_pos = 0; m_ch = 0; m_q = 0; m_fc = 0; m_err = 0;
      e_d = 0; e_u = 0;
      return;
    end
    if (!m_sync) begin
      m_ch = int'(ch % N);
      m_q = q;
      m_pos = 0;
      if (v && l) m_sync = 1;
    end else if (v) begin
      if (m_pos == m_ch / LANES && !(!l && m_pos == NB - 1)) begin
        e_v = 1'b1;
        e_d = d[(m_ch % LANES)*32 +: 32];
        e_u = m_ch;
      end
      if (l) begin
        if (m_pos == NB - 1) m_fc = m_fc + 1;
        else set = 1'b1;
        m_pos = 0;
        m_ch = int'(ch % N);
        m_q = q;
      end else if (m_pos == NB - 1) begin
        set = 1'b1;
        m_sync = 0;
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    if (set) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  task automatic cycle(input bit rst, v, l, clr, input logic [DW-1:0] d,
                       input logic [31:0] ch, q);
    areset = rst; s_axis_tvalid = v; s_axis_tlast = l; ERR_CLR = clr;
    s_axis_tdata = d; CH_REG = ch; QOUT_REG = q;
    @(posedge aclk);
    model_step(rst, v, l, clr, d, ch, q);
    #1;
  endtask

  task automatic chk_model(input int i);
    chk($sformatf("rnd%0d_tvalid", i), 64'(m_axis_tvalid), 64'(e_v));
    chk($sformatf("rnd%0d_tdata", i), 64'(m_axis_tdata), 64'(e_d));
    chk($sformatf("rnd%0d_tuser", i), 64'(m_axis_tuser), 64'(e_u));
    chk($sformatf("rnd%0d_sync_err", i), 64'(sync_err), 64'(m_err));
    chk($sformatf("rnd%0d_frame_cnt", i), 64'(frame_cnt), 64'(m_fc));
    chk($sformatf("rnd%0d_qout", i), 64'(qout_o), 64'(m_q));
  endtask

  initial begin
    logic [31:0]   rch, rq;
    logic [DW-1:0] rd;
    bit            rv, rl, rc, rr;

    areset = 1'b1; s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0;
    CH_REG = 0; QOUT_REG = 0; ERR_CLR = 0;

    // reset, then the sync tlast beat (discarded)
    add(1,0,0,0, 0,19,5, 0,0,0,0, 0,0,0);
    add(0,1,1,0, 15,19,5, 0,0,0,0, 0,0,5);
    // frame 1: channel 19 -> beat 2 lane 3
    for (int b = 0; b < 8; b++)
      add(0,1,b==7,0, b,19,5, b==2, b>=2?2:0, b>=2?3:0, b>=2?19:0, 0, b==7?1:0, 5);
    // frame 2: gap cycle, config change mid-frame takes effect only after tlast
    for (int b = 0; b < 8; b++) begin
      if (b == 2) add(0,0,0,0, 0,19,5, 0,2,3,19, 0,1,5);
      add(0,1,b==7,0, b,b>=4?63:19,b>=4?9:5, b==2, 2,3,19, 0, b==7?2:1, b==7?9:5);
    end
    // frame 3: channel 63 -> beat 7 lane 7
    for (int b = 0; b < 8; b++)
      add(0,1,b==7,0, b,63,9, b==7, b==7?7:2, b==7?7:3, b==7?63:19, 0, b==7?3:2, 9);
    // frame 4: early tlast at cnt 5 with simultaneous ERR_CLR; then ERR_CLR alone
    for (int b = 0; b < 6; b++)
      add(0,1,b==5,b==5, b,63,9, 0,7,7,63, b==5, 3, 9);
    add(0,0,0,1, 0,63,9, 0,7,7,63, 0,3,9);
    // frame 5: extraction resumes normally
    for (int b = 0; b < 8; b++)
      add(0,1,b==7,0, b,63,9, b==7,7,7,63, 0, b==7?4:3, 9);
    // frame 6: missing tlast, no output on the erroring beat
    for (int b = 0; b < 8; b++)
      add(0,1,0,0, b,63,9, 0,7,7,63, b==7, 4, 9);
    // sync wait: config tracks inputs, tlast beat re-syncs
    add(0,1,0,0, 0,19,3, 0,7,7,63, 1,4,3);
    add(0,1,1,0, 7,19,3, 0,7,7,63, 1,4,3);
    for (int b = 0; b < 8; b++)
      add(0,1,b==7,0, b,19,3, b==2, b>=2?2:7, b>=2?3:7, b>=2?19:63, 1, b==7?5:4, 3);
    // areset at beat 3, then no extraction until a new tlast
    for (int b = 0; b < 3; b++)
      add(0,1,0,0, b,19,3, b==2, 2,3,19, 1,5,3);
    add(1,1,0,0, 3,19,3, 0,0,0,0, 0,0,0);
    for (int b = 0; b < 3; b++)
      add(0,1,0,0, b,19,3, 0,0,0,0, 0,0,3);
    add(0,1,1,0, 7,19,3, 0,0,0,0, 0,0,3);
    for (int b = 0; b < 3; b++)
      add(0,1,0,0, b,19,3, b==2, b==2?2:0, b==2?3:0, b==2?19:0, 0,0,3);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].clr, tag_data(tbl[i].beat),
            32'(tbl[i].ch), 32'(tbl[i].q));
      chk($sformatf("row%0d_tvalid", i), 64'(m_axis_tvalid), 64'(tbl[i].ev));
      chk($sformatf("row%0d_tdata", i), 64'(m_axis_tdata), 64'({16'(tbl[i].eb), 16'(tbl[i].el)}));
      chk($sformatf("row%0d_tuser", i), 64'(m_axis_tuser), 64'(tbl[i].eu));
      chk($sformatf("row%0d_sync_err", i), 64'(sync_err), 64'(tbl[i].eerr));
      chk($sformatf("row%0d_frame_cnt", i), 64'(frame_cnt), 64'(tbl[i].efc));
      chk($sformatf("row%0d_qout", i), 64'(qout_o), 64'(tbl[i].eq));
    end

    // randomized traffic against the reference model
    rch = 32'd0; rq = 32'd0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, rch, rq);
    chk_model(0);
    for (int i = 1; i < 4000; i++) begin
      rv = ($urandom % 4) != 0;
      if (m_sync) begin
        rl = (m_pos == NB - 1);
        if (($urandom % 100) < 4) rl = !rl;
      end else begin
        rl = ($urandom % 4) == 0;
      end
      rc = ($urandom % 30) == 0;
      rr = ($urandom % 500) == 0;
      if (($urandom % 20) == 0) rch = $urandom;
      if (($urandom % 20) == 0) rq = $urandom;
      for (int k = 0; k < LANES; k++) rd[k*32 +: 32] = $urandom;
      cycle(rr, rv, rl, rc, rd, rch, rq);
      chk_model(i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
